// File: rtl/iob_dual_bus_arbiter.sv
// iob_dual_bus_arbiter
// Shares one native memory port between two masters (m0 = CPU instruction bus,
// m1 = CPU data bus). One transaction is granted at a time, using round-robin
// (PRIO_MODE=0) or fixed priority with m1 winning (PRIO_MODE=1). A watchdog
// completes a hung transaction with ERR_DATA and sets a sticky error flag.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   m0_* / m1_*            master request (valid/addr/wdata/wstrb) and response (rdata/ready)
//   s_valid/s_addr/...     latched request to the shared slave
//   s_rdata, s_ready       slave response
//   grant                  one-hot owner of the current transaction, 00 when idle
//   timeout_err, err_clr   sticky watchdog flag and its synchronous clear
module iob_dual_bus_arbiter #(
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       TIMEOUT_W = 8,
   parameter int unsigned       PRIO_MODE = 0,
   parameter logic [DATA_W-1:0] ERR_DATA  = 32'hDEADBEEF
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  m0_valid,
   input  logic [ADDR_W-1:0]     m0_addr,
   input  logic [DATA_W-1:0]     m0_wdata,
   input  logic [DATA_W/8-1:0]   m0_wstrb,
   output logic [DATA_W-1:0]     m0_rdata,
   output logic                  m0_ready,
   input  logic                  m1_valid,
   input  logic [ADDR_W-1:0]     m1_addr,
   input  logic [DATA_W-1:0]     m1_wdata,
   input  logic [DATA_W/8-1:0]   m1_wstrb,
   output logic [DATA_W-1:0]     m1_rdata,
   output logic                  m1_ready,
   output logic                  s_valid,
   output logic [ADDR_W-1:0]     s_addr,
   output logic [DATA_W-1:0]     s_wdata,
   output logic [DATA_W/8-1:0]   s_wstrb,
   input  logic [DATA_W-1:0]     s_rdata,
   input  logic                  s_ready,
   output logic [1:0]            grant,
   output logic                  timeout_err,
   input  logic                  err_clr
);

   localparam logic                 STATE_IDLE = 1'b0;
   localparam logic                 STATE_BUSY = 1'b1;
   localparam logic [TIMEOUT_W-1:0] CNT_MAX    = '1;

   logic                 state_q;
   logic [1:0]           grant_q;
   logic                 last_q;   // 1 = master 1 was granted last
   logic [TIMEOUT_W-1:0] cnt_q;
   logic                 err_q;
   logic [ADDR_W-1:0]    addr_q;
   logic [DATA_W-1:0]    wdata_q;
   logic [DATA_W/8-1:0]  wstrb_q;

   logic                 pick_m1;
   logic                 timeout_hit;
   logic                 done;
   logic [DATA_W-1:0]    resp_data;

   always_comb begin
      pick_m1 = 1'b0;
      if (m1_valid && !m0_valid) begin
         pick_m1 = 1'b1;
      end else if (m1_valid && m0_valid) begin
         pick_m1 = (PRIO_MODE == 1) ? 1'b1 : ~last_q;
      end
   end

   // A slave ready coinciding with the terminal count is a normal completion.
   assign timeout_hit = (state_q == STATE_BUSY) && !s_ready && (cnt_q == CNT_MAX);
   assign done        = (state_q == STATE_BUSY) && (s_ready || timeout_hit);
   assign resp_data   = s_ready ? s_rdata : ERR_DATA;

   assign m0_ready = done && grant_q[0];
   assign m1_ready = done && grant_q[1];
   assign m0_rdata = m0_ready ? resp_data : '0;
   assign m1_rdata = m1_ready ? resp_data : '0;

   assign s_valid     = (state_q == STATE_BUSY);
   assign s_addr      = addr_q;
   assign s_wdata     = wdata_q;
   assign s_wstrb     = wstrb_q;
   assign grant       = grant_q;
   assign timeout_err = err_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= STATE_IDLE;
         grant_q <= 2'b00;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         wstrb_q <= '0;
      end else begin
         case (state_q)
            STATE_IDLE: begin
               if (m0_valid || m1_valid) begin
                  state_q <= STATE_BUSY;
                  grant_q <= pick_m1 ? 2'b10 : 2'b01;
                  addr_q  <= pick_m1 ? m1_addr  : m0_addr;
                  wdata_q <= pick_m1 ? m1_wdata : m0_wdata;
                  wstrb_q <= pick_m1 ? m1_wstrb : m0_wstrb;
                  cnt_q   <= '0;
               end
            end
            default: begin
               if (done) begin
                  state_q <= STATE_IDLE;
                  grant_q <= 2'b00;
                  last_q  <= grant_q[1];
                  cnt_q   <= '0;
               end else if (cnt_q != CNT_MAX) begin
                  cnt_q <= cnt_q + TIMEOUT_W'(1);
               end
            end
         endcase
      end
   end

   // Set wins over a simultaneous clear.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_q <= 1'b0;
      end else if (timeout_hit) begin
         err_q <= 1'b1;
      end else if (err_clr) begin
         err_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_iob_dual_bus_arbiter.sv
module tb_iob_dual_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        m0_valid = 1'b0, m1_valid = 1'b0;
   logic [31:0] m0_addr = '0, m1_addr = '0, m0_wdata = '0, m1_wdata = '0;
   logic [3:0]  m0_wstrb = '0, m1_wstrb = '0;
   logic [31:0] s_rdata = '0;
   logic        s_ready = 1'b0;
   logic        err_clr = 1'b0;

   // Instance A: round-robin; instance B: fixed priority. Both see identical stimulus.
   logic [31:0] a_m0_rdata, a_m1_rdata, a_s_addr, a_s_wdata;
   logic        a_m0_ready, a_m1_ready, a_s_valid, a_err;
   logic [3:0]  a_s_wstrb;
   logic [1:0]  a_grant;
   logic [31:0] b_m0_rdata, b_m1_rdata, b_s_addr, b_s_wdata;
   logic        b_m0_ready, b_m1_ready, b_s_valid, b_err;
   logic [3:0]  b_s_wstrb;
   logic [1:0]  b_grant;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   iob_dual_bus_arbiter #(.TIMEOUT_W(4), .PRIO_MODE(0)) dut_a (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_rdata(a_m0_rdata), .m0_ready(a_m0_ready),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_rdata(a_m1_rdata), .m1_ready(a_m1_ready),
      .s_valid(a_s_valid), .s_addr(a_s_addr), .s_wdata(a_s_wdata), .s_wstrb(a_s_wstrb),
      .s_rdata(s_rdata), .s_ready(s_ready),
      .grant(a_grant), .timeout_err(a_err), .err_clr(err_clr)
   );

   iob_dual_bus_arbiter #(.TIMEOUT_W(4), .PRIO_MODE(1)) dut_b (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_rdata(b_m0_rdata), .m0_ready(b_m0_ready),
      .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_rdata(b_m1_rdata), .m1_ready(b_m1_ready),
      .s_valid(b_s_valid), .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_wstrb(b_s_wstrb),
      .s_rdata(s_rdata), .s_ready(s_ready),
      .grant(b_grant), .timeout_err(b_err), .err_clr(err_clr)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      #3;
      resetn = 1'b1;
      step();
   endtask

   initial begin
      logic [1:0] exp_g;

      // 1. Reset state and single m0 read
      #2;
      chk("rst_s_valid", {31'd0, a_s_valid}, 32'd0);
      chk("rst_grant", {30'd0, a_grant}, 32'd0);
      chk("rst_err", {31'd0, a_err}, 32'd0);
      chk("rst_s_addr", a_s_addr, 32'd0);
      resetn = 1'b1;
      step();
      m0_valid = 1'b1; m0_addr = 32'h100; m0_wstrb = 4'h0;
      #1;
      chk("t1_no_early_valid", {31'd0, a_s_valid}, 32'd0);
      step();
      chk("t1_s_valid", {31'd0, a_s_valid}, 32'd1);
      chk("t1_s_addr", a_s_addr, 32'h100);
      chk("t1_grant", {30'd0, a_grant}, 32'd1);
      chk("t1_no_ready", {31'd0, a_m0_ready}, 32'd0);
      step(); step(); step();
      s_ready = 1'b1; s_rdata = 32'h12345678;
      #1;
      chk("t1_m0_ready", {31'd0, a_m0_ready}, 32'd1);
      chk("t1_m0_rdata", a_m0_rdata, 32'h12345678);
      chk("t1_m1_ready", {31'd0, a_m1_ready}, 32'd0);
      chk("t1_m1_rdata", a_m1_rdata, 32'd0);
      step();
      s_ready = 1'b0; m0_valid = 1'b0;
      #1;
      chk("t1_idle_s_valid", {31'd0, a_s_valid}, 32'd0);
      chk("t1_idle_grant", {30'd0, a_grant}, 32'd0);
      chk("t1_idle_ready", {31'd0, a_m0_ready}, 32'd0);
      step();
      chk("t1_no_regrant", {31'd0, a_s_valid}, 32'd0);

      // 2/3. Both masters requesting continuously
      do_reset();
      m0_valid = 1'b1; m0_addr = 32'h40;
      m1_valid = 1'b1; m1_addr = 32'h80;
      for (int i = 0; i < 4; i++) begin
         exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
         step();
         chk($sformatf("t2_rr_grant%0d", i), {30'd0, a_grant}, {30'd0, exp_g});
         chk($sformatf("t2_rr_addr%0d", i), a_s_addr, (i % 2 == 0) ? 32'h40 : 32'h80);
         chk($sformatf("t3_prio_grant%0d", i), {30'd0, b_grant}, 32'd2);
         step();
         s_ready = 1'b1; s_rdata = 32'h1000 + i;
         #1;
         chk($sformatf("t2_rr_m0rdy%0d", i), {31'd0, a_m0_ready}, {31'd0, exp_g[0]});
         chk($sformatf("t3_prio_m1rdy%0d", i), {31'd0, b_m1_ready}, 32'd1);
         chk($sformatf("t3_prio_m0rdy%0d", i), {31'd0, b_m0_ready}, 32'd0);
         step();
         s_ready = 1'b0;
      end
      m1_valid = 1'b0;
      step();
      chk("t3_prio_m0_after_m1", {30'd0, b_grant}, 32'd1);
      step();
      s_ready = 1'b1; s_rdata = 32'h77;
      #1;
      chk("t3_prio_m0_rdata", b_m0_rdata, 32'h77);
      step();
      s_ready = 1'b0; m0_valid = 1'b0;

      // 4. m1 write, inputs ignored while busy
      m1_valid = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'hA5A5A5A5; m1_wstrb = 4'hF;
      step();
      chk("t4_grant", {30'd0, a_grant}, 32'd2);
      chk("t4_s_addr", a_s_addr, 32'h2000);
      chk("t4_s_wstrb", {28'd0, a_s_wstrb}, 32'hF);
      chk("t4_s_wdata", a_s_wdata, 32'hA5A5A5A5);
      m1_wdata = 32'h0; m1_addr = 32'h3000;
      step();
      chk("t4_s_wdata_held", a_s_wdata, 32'hA5A5A5A5);
      chk("t4_s_addr_held", a_s_addr, 32'h2000);
      s_ready = 1'b1; s_rdata = 32'h55;
      #1;
      chk("t4_m1_ready", {31'd0, a_m1_ready}, 32'd1);
      chk("t4_m0_ready", {31'd0, a_m0_ready}, 32'd0);
      step();
      s_ready = 1'b0; m1_valid = 1'b0; m1_wstrb = 4'h0;

      // 5. Watchdog timeout (TIMEOUT_W=4 -> terminal count 15)
      m0_valid = 1'b1; m0_addr = 32'h500;
      step();
      chk("t5_busy", {31'd0, a_s_valid}, 32'd1);
      for (int i = 0; i < 14; i++) begin
         step();
         chk($sformatf("t5_wait%0d", i), {31'd0, a_m0_ready}, 32'd0);
      end
      step();
      err_clr = 1'b1;  // coincident clear loses against the set
      #1;
      chk("t5_to_ready", {31'd0, a_m0_ready}, 32'd1);
      chk("t5_to_rdata", a_m0_rdata, 32'hDEADBEEF);
      chk("t5_err_not_yet", {31'd0, a_err}, 32'd0);
      step();
      err_clr = 1'b0; m0_valid = 1'b0;
      chk("t5_err_set", {31'd0, a_err}, 32'd1);
      chk("t5_s_valid_drop", {31'd0, a_s_valid}, 32'd0);
      step();
      chk("t5_err_sticky", {31'd0, a_err}, 32'd1);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      chk("t5_err_cleared", {31'd0, a_err}, 32'd0);

      m0_valid = 1'b1;
      step();
      for (int i = 0; i < 14; i++) step();
      step();
      s_ready = 1'b1; s_rdata = 32'hCAFEF00D;
      #1;
      chk("t5_edge_ready", {31'd0, a_m0_ready}, 32'd1);
      chk("t5_edge_rdata", a_m0_rdata, 32'hCAFEF00D);
      step();
      s_ready = 1'b0; m0_valid = 1'b0;
      chk("t5_edge_no_err", {31'd0, a_err}, 32'd0);

      // 6. Asynchronous reset mid-BUSY
      m1_valid = 1'b1; m1_addr = 32'h600;
      step();
      chk("t6_busy", {30'd0, a_grant}, 32'd2);
      step();
      s_ready = 1'b1;
      #2;
      resetn = 1'b0;
      #1;
      chk("t6_rst_s_valid", {31'd0, a_s_valid}, 32'd0);
      chk("t6_rst_grant", {30'd0, a_grant}, 32'd0);
      chk("t6_rst_ready", {31'd0, a_m1_ready}, 32'd0);
      s_ready = 1'b0; m1_valid = 1'b0;
      #1;
      resetn = 1'b1;
      step();
      m0_valid = 1'b1; m0_addr = 32'h700;
      step();
      chk("t6_after_grant", {30'd0, a_grant}, 32'd1);
      chk("t6_after_addr", a_s_addr, 32'h700);
      s_ready = 1'b1; s_rdata = 32'h99;
      #1;
      chk("t6_after_rdata", a_m0_rdata, 32'h99);
      step();
      s_ready = 1'b0; m0_valid = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/iob_dual_bus_arbiter.md
Name: iob_dual_bus_arbiter

Overview:
- Shares one native memory port (valid/address/wdata/wstrb/rdata/ready) between two masters: master 0 is the CPU instruction bus, master 1 the CPU data bus.
- Sits between the CPU wrapper's split ibus/dbus and a single-ported memory or interconnect, so the system can run from one shared memory.
- Grants one transaction at a time, with round-robin or fixed-priority arbitration.
- A watchdog completes hung transactions and flags an error.

Parameters:
ADDR_W, 32, address width of masters and slave
DATA_W, 32, data width; wstrb width is DATA_W/8
TIMEOUT_W, 8, width of the watchdog counter; timeout fires after 2^TIMEOUT_W-1 wait cycles
PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority with master 1 (data) winning
ERR_DATA, 32'hDEADBEEF, rdata returned on a timed-out read

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
m0_valid  in  1  instr request; held until m0_ready
m0_addr  in  ADDR_W  instr address
m0_wdata  in  DATA_W  instr write data (normally unused)
m0_wstrb  in  DATA_W/8  instr byte strobes; 0 = read
m0_rdata  out  DATA_W  instr read data, valid when m0_ready
m0_ready  out  1  instr completion pulse
m1_valid, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_ready  same as m0, for the data master
s_valid  out  1  request to the shared slave
s_addr  out  ADDR_W  latched address
s_wdata  out  DATA_W  latched write data
s_wstrb  out  DATA_W/8  latched strobes
s_rdata  in  DATA_W  slave read data
s_ready  in  1  slave completion
grant  out  2  one-hot owner of the current transaction; 00 when idle
timeout_err  out  1  sticky watchdog flag
err_clr  in  1  synchronous clear of timeout_err

Behaviour:
- Reset (async, resetn=0): state IDLE; s_valid, grant, timeout_err and the watchdog counter are 0; s_addr/s_wdata/s_wstrb are 0; last-granted pointer = master 1, so master 0 wins the first tie. m*_ready = 0.
- FSM states: IDLE, BUSY.
- IDLE, no m*_valid: stay in IDLE, all outputs low.
- IDLE, one valid: at the next edge, latch that master's addr/wdata/wstrb into the s_* registers, set grant, set s_valid=1, go to BUSY.
- IDLE, both valid:
  - PRIO_MODE=0: grant the master not granted last.
  - PRIO_MODE=1: master 1 always wins.
- Grant latency: 1 cycle from valid in IDLE to s_valid.
- BUSY: s_valid, s_* and grant are stable; masters' input changes are ignored.
- s_ready=1 in BUSY:
  - Combinationally in the same cycle, the granted m*_ready=1 and its m*_rdata=s_rdata.
  - At the edge: s_valid=0, grant=00, last-granted pointer updated, counter cleared, state to IDLE.
- The non-granted master sees ready=0. Its rdata is 0 whenever it is not the completing master.
- Minimum spacing between slave transactions is 2 cycles: 1 BUSY completion cycle plus 1 IDLE arbitration cycle.
- A master dropping valid after its ready (CPU behaviour) is not re-granted. A master still valid in IDLE is re-arbitrated normally.
- Watchdog:
  - The counter increments on every BUSY cycle with s_ready=0.
  - When it reaches 2^TIMEOUT_W-1 with s_ready still 0:
    - the granted m*_ready pulses for 1 cycle with m*_rdata=ERR_DATA;
    - timeout_err is set;
    - the FSM goes to IDLE and s_valid drops.
  - If s_ready and the timeout coincide, it is a normal completion: s_rdata is returned and no error is raised.
- timeout_err is sticky until err_clr=1. If set and clear happen in the same cycle, set wins.
- A master that deasserts valid while granted is a protocol violation; the transaction still completes on the slave and the ready is still driven.
- resetn asserted mid-BUSY aborts immediately: s_valid=0 and no ready pulse. Masters must re-issue after reset.
- Counter width arithmetic is TIMEOUT_W bits with no wrap: the counter saturates at the terminal count, which triggers completion.

Test Plan:
1. Reset, then m0_valid with addr 0x100, s_ready returned 3 cycles after s_valid with s_rdata 0x12345678 -> s_valid rises 1 cycle after m0_valid; s_addr=0x100; grant=01; m0_ready pulses once with m0_rdata=0x12345678; m1_ready stays 0.
2. PRIO_MODE=0, m0 and m1 valid simultaneously and continuously re-requesting, slave ready after 1 cycle -> grants alternate 01,10,01,10. Master 0 wins first.
3. PRIO_MODE=1, both valid -> grant=10 first; m0 is served only once m1 drops valid.
4. m1 write: addr 0x2000, wdata 0xA5A5A5A5, wstrb 0xF -> s_wstrb=0xF and s_wdata latched. Changing m1_wdata while BUSY does not alter s_wdata.
5. TIMEOUT_W=4, slave never readies -> after 15 BUSY cycles the granted ready pulses with rdata=0xDEADBEEF and timeout_err=1 stays set. Pulsing err_clr clears it. s_ready arriving at exactly cycle 15 instead -> normal data returned and no error.
6. resetn pulsed low mid-BUSY -> s_valid, grant and ready all 0 asynchronously. After release, IDLE and a new request is serviced normally.
